// File: rtl/uart_byte_receiver.sv
// 16x-oversampled 8N1 UART receiver with majority-vote sampling; UART_RX_FIFO_EN selects a 4-entry FIFO instead of one holding register.
// Latency: 2-clock input sync; byte is pushed at stop-bit tick 9 and is visible one clock later (~9.6 bit periods after the start edge).
// Backpressure: rx_valid/rx_ready; when the buffer is full a new byte is dropped and rx_overrun pulses, unless a pop happens in the same cycle.
module uart_byte_receiver #(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_framing_err,
    output logic       rx_overrun,
    output logic       rx_idle
);

    localparam logic [32:0] ACC_INC = 33'(BAUD * 16);
    localparam logic [32:0] ACC_LIM = 33'(CLK_FREQ);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic        rxd_s1;
    logic        rxd_s2;
    logic        rxd_d;
    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic        tick;
    state_t      state;
    logic [3:0]  tcnt;
    logic [3:0]  hcnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        v7;
    logic        v8;
    logic        vote;
    logic        push_vld;
    logic [7:0]  push_dat;
    logic        pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= RxD;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    // Fractional accumulator keeps the long-term tick rate exact at 16x baud.
    assign acc_sum = {1'b0, acc} + ACC_INC;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc  <= 32'd0;
            tick <= 1'b0;
        end else if (acc_sum >= ACC_LIM) begin
            acc  <= 32'(acc_sum - ACC_LIM);
            tick <= 1'b1;
        end else begin
            acc  <= acc_sum[31:0];
            tick <= 1'b0;
        end
    end

    // Ticks 7 and 8 are held in v7/v8; tick 9 uses the live sample.
    assign vote    = (v7 & v8) | (v7 & rxd_s2) | (v8 & rxd_s2);
    assign rx_idle = (state == IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= WAIT_HIGH;
            tcnt           <= 4'd0;
            hcnt           <= 4'd0;
            bit_idx        <= 3'd0;
            shreg          <= 8'd0;
            v7             <= 1'b1;
            v8             <= 1'b1;
            push_vld       <= 1'b0;
            push_dat       <= 8'd0;
            rx_framing_err <= 1'b0;
        end else begin
            push_vld       <= 1'b0;
            rx_framing_err <= 1'b0;
            if (tick && state != IDLE) begin
                tcnt <= tcnt + 4'd1;
                if (tcnt == 4'd7) v7 <= rxd_s2;
                if (tcnt == 4'd8) v8 <= rxd_s2;
            end
            case (state)
                IDLE: begin
                    if (rxd_d && !rxd_s2) begin
                        tcnt  <= 4'd0;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tcnt == 4'd9 && vote) begin
                            state <= IDLE;
                        end else if (tcnt == 4'd15) begin
                            bit_idx <= 3'd0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tcnt == 4'd9) shreg <= {vote, shreg[7:1]};
                        if (tcnt == 4'd15) begin
                            if (bit_idx == 3'd7) state <= STOP;
                            else                 bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick && tcnt == 4'd9) begin
                        if (vote) begin
                            push_vld <= 1'b1;
                            push_dat <= shreg;
                            state    <= IDLE;
                        end else begin
                            rx_framing_err <= 1'b1;
                            hcnt           <= 4'd0;
                            state          <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A low line at any clock restarts the 16-tick high qualification.
                    if (!rxd_s2) begin
                        hcnt <= 4'd0;
                    end else if (tick) begin
                        if (hcnt == 4'd15) begin
                            hcnt  <= 4'd0;
                            state <= IDLE;
                        end else begin
                            hcnt <= hcnt + 4'd1;
                        end
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

    assign pop = rx_valid && rx_ready;

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wptr;
    logic [1:0] rptr;
    logic [2:0] count;
    logic       push_ok;

    assign push_ok  = push_vld && (count != 3'd4 || pop);
    assign rx_valid = (count != 3'd0);
    assign rx_data  = mem[rptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'd0;
            wptr       <= 2'd0;
            rptr       <= 2'd0;
            count      <= 3'd0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= push_vld && !push_ok;
            if (push_ok) begin
                mem[wptr] <= push_dat;
                wptr      <= wptr + 2'd1;
            end
            if (pop) rptr <= rptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
`else
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (push_vld) begin
                if (!rx_valid || pop) begin
                    rx_data  <= push_dat;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (pop) begin
                rx_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed-frame bench for uart_byte_receiver: expected bytes are queued at stimulus time and compared by a monitor on each pop.
module tb_uart_byte_receiver;

    localparam int BIT = 217;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       RxD      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_framing_err;
    logic       rx_overrun;
    logic       rx_idle;

    int         n_checks   = 0;
    int         n_pass     = 0;
    int         fe_cnt     = 0;
    int         ov_cnt     = 0;
    int         vld_cycles = 0;
    int         fe_base;
    int         ov_base;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #20 clock = ~clock;

    uart_byte_receiver #(
        .CLK_FREQ(25_000_000),
        .BAUD    (115200)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .RxD           (RxD),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_framing_err(rx_framing_err),
        .rx_overrun    (rx_overrun),
        .rx_idle       (rx_idle)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every accepted byte and tallies error pulses.
    always @(negedge clock) begin
        if (reset) begin
            if (rx_framing_err) fe_cnt++;
            if (rx_overrun) ov_cnt++;
            if (rx_valid && rx_ready) begin
                vld_cycles++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, rx_data}, 32'h100);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, mon_exp});
                end
            end
        end
    end

    task automatic line(input logic v, input int nbits);
        RxD = v;
        repeat (nbits * BIT) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v);
        line(1'b0, 1);
        for (int i = 0; i < 8; i++) line(b[i], 1);
        line(stop_v, 1);
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clock);
            k++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        repeat (5) @(negedge clock);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_rx_valid", {31'd0, rx_valid}, 0);
        check("reset_framing", {31'd0, rx_framing_err}, 0);
        check("reset_overrun", {31'd0, rx_overrun}, 0);
        check("reset_idle", {31'd0, rx_idle}, 0);
        reset = 1'b1;
        line(1'b1, 2);
        check("idle_after_reset", {31'd0, rx_idle}, 1);

        // 1: basic receive with consumer always ready
        rx_ready = 1'b1;
        vld_cycles = 0;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        line(1'b1, 1);
        drain(500);
        check("basic_valid_cycles", vld_cycles, 1);
        check("basic_framing_cnt", fe_cnt, 0);
        check("basic_overrun_cnt", ov_cnt, 0);
        check("basic_idle", {31'd0, rx_idle}, 1);

        // 2: 40-clock glitch is a false start
        RxD = 1'b0;
        repeat (40) @(negedge clock);
        RxD = 1'b1;
        repeat (2 * BIT) @(negedge clock);
        check("glitch_idle", {31'd0, rx_idle}, 1);
        check("glitch_framing_cnt", fe_cnt, 0);
        check("glitch_no_byte", vld_cycles, 1);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1);
        line(1'b1, 1);
        drain(500);

        // 3: framing error then recovery
        send(8'h3C, 1'b0);
        line(1'b0, 1);
        line(1'b1, 2);
        check("framing_pulse_cnt", fe_cnt, 1);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1);
        line(1'b1, 1);
        drain(500);
        check("framing_final_cnt", fe_cnt, 1);
        check("framing_overrun_cnt", ov_cnt, 0);

        // 4/5: overrun with consumer stalled
        rx_ready = 1'b0;
`ifndef UART_RX_FIFO_EN
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        line(1'b1, 1);
        check("overrun_none_yet", ov_cnt, 0);
        send(8'h22, 1'b1);
        line(1'b1, 1);
        check("overrun_cnt", ov_cnt, 1);
        check("overrun_data_held", {24'd0, rx_data}, 32'h11);
        check("overrun_valid_held", {31'd0, rx_valid}, 1);
        @(posedge clock);
        #1 rx_ready = 1'b1;
        @(posedge clock);
        #1 rx_ready = 1'b0;
        @(negedge clock);
        check("overrun_valid_after_pop", {31'd0, rx_valid}, 0);
`else
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send(8'(i), 1'b1);
            line(1'b1, 1);
            if (i == 4) check("fifo_no_overrun_at_4", ov_cnt, 0);
        end
        check("fifo_overrun_cnt", ov_cnt, 1);
        check("fifo_head", {24'd0, rx_data}, 32'h01);
        check("fifo_valid_held", {31'd0, rx_valid}, 1);
        @(posedge clock);
        #1 rx_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1 rx_ready = 1'b0;
        @(negedge clock);
        check("fifo_valid_after_pops", {31'd0, rx_valid}, 0);
`endif
        drain(10);

        // 6: reset in the middle of frame 0x00
        rx_ready = 1'b1;
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        line(1'b0, 3);
        repeat (BIT / 2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("midreset_valid", {31'd0, rx_valid}, 0);
        check("midreset_data", {24'd0, rx_data}, 32'h00);
        check("midreset_idle", {31'd0, rx_idle}, 0);
        reset = 1'b1;
        repeat (BIT - BIT / 2 - 3) @(negedge clock);
        line(1'b0, 5);
        line(1'b1, 2);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1);
        line(1'b1, 1);
        drain(500);
        check("midreset_framing_cnt", fe_cnt, fe_base);
        check("midreset_overrun_cnt", ov_cnt, ov_base);
        check("midreset_final_idle", {31'd0, rx_idle}, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
